// File: rtl/cdb_writeback_scheduler.sv
// Common Data Bus arbiter and register status (Qi) table for a Tomasulo core.
// One result is broadcast per cycle and written back only by the register's latest producer.
module cdb_writeback_scheduler #(
  parameter int NUM_FU = 3,
  parameter int TAGW   = 3,
  parameter int DW     = 16
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   issue_valid,
  input  logic [2:0]             issue_rd,
  input  logic [TAGW-1:0]        issue_tag,
  input  logic [2:0]             src_a_addr,
  input  logic [2:0]             src_b_addr,
  output logic [TAGW-1:0]        src_a_tag,
  output logic [TAGW-1:0]        src_b_tag,
  output logic                   src_a_fwd,
  output logic                   src_b_fwd,
  output logic [DW-1:0]          src_a_data,
  output logic [DW-1:0]          src_b_data,
  // Handshake: an FU holds fu_req/fu_tag/fu_data stable until it sees fu_grant;
  // the rising edge that ends a granted cycle consumes the result, a new one may follow next cycle.
  input  logic [NUM_FU-1:0]      fu_req,
  input  logic [NUM_FU*TAGW-1:0] fu_tag,
  input  logic [NUM_FU*DW-1:0]   fu_data,
  output logic [NUM_FU-1:0]      fu_grant,
  output logic                   cdb_valid,
  output logic [TAGW-1:0]        cdb_tag,
  output logic [DW-1:0]          cdb_data,
  output logic                   write,
  output logic [2:0]             address,
  output logic [DW-1:0]          data
);

  localparam int PW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  logic [TAGW-1:0]   qi [0:7];
  logic [PW-1:0]     ptr;
  logic [NUM_FU-1:0] elig;
  logic              win_valid;
  logic [PW-1:0]     win;
  logic [TAGW-1:0]   win_tag;
  logic [DW-1:0]     win_data;
  logic              match;
  logic [2:0]        match_r;

  // Requests are masked during reset so FUs keep their results pending.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_FU; i++)
      elig[i] = reset_n && fu_req[i] && (fu_tag[i*TAGW +: TAGW] != '0);
  end

  // Round-robin: first pass covers FUs above the pointer, second pass wraps to 0..ptr.
  always_comb begin
    win_valid = 1'b0;
    win       = '0;
    win_tag   = '0;
    win_data  = '0;
    fu_grant  = '0;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (!win_valid && elig[i] && ((p == 0) == (i > int'(ptr)))) begin
          win_valid   = 1'b1;
          win         = PW'(i);
          win_tag     = fu_tag[i*TAGW +: TAGW];
          win_data    = fu_data[i*DW +: DW];
          fu_grant[i] = 1'b1;
        end
      end
    end
  end

  // Renaming keeps each tag in at most one Qi entry, so a single match suffices.
  always_comb begin
    match   = 1'b0;
    match_r = '0;
    for (int r = 1; r < 8; r++) begin
      if (win_valid && (qi[r] == win_tag)) begin
        match   = 1'b1;
        match_r = 3'(r);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int r = 0; r < 8; r++) qi[r] <= '0;
      ptr       <= PW'(NUM_FU - 1);
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_data  <= '0;
      write     <= 1'b0;
      address   <= '0;
      data      <= '0;
    end else begin
      cdb_valid <= win_valid;
      write     <= match;
      if (win_valid) begin
        ptr      <= win;
        cdb_tag  <= win_tag;
        cdb_data <= win_data;
      end
      if (match) begin
        address     <= match_r;
        data        <= win_data;
        qi[match_r] <= '0;
      end
      // Issue is applied last so a same-edge rename of the cleared register wins.
      if (issue_valid && (issue_rd != 3'd0)) qi[issue_rd] <= issue_tag;
    end
  end

  // Returns {fwd, tag, data}; a pending bank write is forwarded ahead of the Qi entry.
  function automatic logic [TAGW+DW:0] lookup(input logic [2:0] a);
    logic [TAGW+DW:0] res;
    res = '0;
    if (a != 3'd0) begin
      if (write && (address == a)) res = {1'b1, {TAGW{1'b0}}, data};
      else                         res = {1'b0, qi[a], {DW{1'b0}}};
    end
    return res;
  endfunction

  always_comb begin
    {src_a_fwd, src_a_tag, src_a_data} = lookup(src_a_addr);
    {src_b_fwd, src_b_tag, src_b_data} = lookup(src_b_addr);
  end

endmodule

// File: tb/tb_cdb_writeback_scheduler.sv
// Directed bench for cdb_writeback_scheduler: reset, arbitration order, writeback,
// superseded results, same-edge issue/clear, forwarding and mid-operation reset.
module tb_cdb_writeback_scheduler;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        issue_valid;
  logic [2:0]  issue_rd;
  logic [2:0]  issue_tag;
  logic [2:0]  src_a_addr, src_b_addr;
  logic [2:0]  src_a_tag, src_b_tag;
  logic        src_a_fwd, src_b_fwd;
  logic [15:0] src_a_data, src_b_data;
  logic [2:0]  fu_req;
  logic [8:0]  fu_tag;
  logic [47:0] fu_data;
  logic [2:0]  fu_grant;
  logic        cdb_valid;
  logic [2:0]  cdb_tag;
  logic [15:0] cdb_data;
  logic        write;
  logic [2:0]  address;
  logic [15:0] data;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  cdb_writeback_scheduler #(.NUM_FU(3), .TAGW(3), .DW(16)) dut (
    .clock(clock), .reset_n(reset_n),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_tag(issue_tag),
    .src_a_addr(src_a_addr), .src_b_addr(src_b_addr),
    .src_a_tag(src_a_tag), .src_b_tag(src_b_tag),
    .src_a_fwd(src_a_fwd), .src_b_fwd(src_b_fwd),
    .src_a_data(src_a_data), .src_b_data(src_b_data),
    .fu_req(fu_req), .fu_tag(fu_tag), .fu_data(fu_data), .fu_grant(fu_grant),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .write(write), .address(address), .data(data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_fu(input int i, input logic r, input logic [2:0] t, input logic [15:0] d);
    fu_req[i]         = r;
    fu_tag[i*3 +: 3]  = t;
    fu_data[i*16 +: 16] = d;
  endtask

  task automatic do_issue(input logic [2:0] rd, input logic [2:0] t);
    issue_valid = 1'b1;
    issue_rd    = rd;
    issue_tag   = t;
  endtask

  task automatic look_a(input logic [2:0] a, input logic [2:0] t, input logic f, input logic [15:0] d);
    src_a_addr = a;
    #1;
    chk($sformatf("src_a_tag[%0d]", a), 32'(src_a_tag), 32'(t));
    chk($sformatf("src_a_fwd[%0d]", a), 32'(src_a_fwd), 32'(f));
    chk($sformatf("src_a_data[%0d]", a), 32'(src_a_data), 32'(d));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] exp_g [4];
    logic [2:0] exp_t [4];
    exp_g = '{3'b001, 3'b010, 3'b100, 3'b001};
    exp_t = '{3'd1, 3'd2, 3'd3, 3'd1};

    reset_n = 1'b0; issue_valid = 1'b0; issue_rd = '0; issue_tag = '0;
    src_a_addr = '0; src_b_addr = '0; fu_req = '0; fu_tag = '0; fu_data = '0;

    // Reset and idle
    tick();
    reset_n = 1'b1;
    chk("rst_cdb_valid", 32'(cdb_valid), 0);
    chk("rst_cdb_tag", 32'(cdb_tag), 0);
    chk("rst_cdb_data", 32'(cdb_data), 0);
    chk("rst_write", 32'(write), 0);
    chk("rst_address", 32'(address), 0);
    chk("rst_data", 32'(data), 0);
    for (int r = 1; r < 8; r++) look_a(3'(r), 3'd0, 1'b0, 16'h0);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("idle_grant", 32'(fu_grant), 0);
      chk("idle_cdb_valid", 32'(cdb_valid), 0);
      chk("idle_write", 32'(write), 0);
    end

    // Round-robin from reset pointer
    set_fu(0, 1'b1, 3'd1, 16'h0A01);
    set_fu(1, 1'b1, 3'd2, 16'h0A02);
    set_fu(2, 1'b1, 3'd3, 16'h0A03);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("rr_grant%0d", k), 32'(fu_grant), 32'(exp_g[k]));
      tick();
      chk($sformatf("rr_cdb_valid%0d", k), 32'(cdb_valid), 1);
      chk($sformatf("rr_cdb_tag%0d", k), 32'(cdb_tag), 32'(exp_t[k]));
      chk($sformatf("rr_write%0d", k), 32'(write), 0);
    end
    fu_req = '0; fu_tag = '0; fu_data = '0;

    // Tag-0 request is never granted
    set_fu(0, 1'b1, 3'd0, 16'h0BAD);
    #1;
    chk("tag0_grant", 32'(fu_grant), 0);
    tick();
    chk("tag0_cdb_valid", 32'(cdb_valid), 0);
    set_fu(1, 1'b1, 3'd5, 16'h0055);
    #1;
    chk("tag0_mix_grant", 32'(fu_grant), 32'(3'b010));
    tick();
    set_fu(1, 1'b0, 3'd0, 16'h0);
    chk("tag0_mix_cdb_valid", 32'(cdb_valid), 1);
    chk("tag0_mix_cdb_tag", 32'(cdb_tag), 5);
    chk("tag0_mix_cdb_data", 32'(cdb_data), 32'h55);
    chk("tag0_mix_write", 32'(write), 0);
    #1;
    chk("tag0_alone_grant", 32'(fu_grant), 0);
    set_fu(0, 1'b0, 3'd0, 16'h0);

    // Single writeback: rd 3 <- tag 2
    do_issue(3'd3, 3'd2);
    tick();
    issue_valid = 1'b0;
    look_a(3'd3, 3'd2, 1'b0, 16'h0);
    set_fu(1, 1'b1, 3'd2, 16'h0042);
    #1;
    chk("wb_grant", 32'(fu_grant), 32'(3'b010));
    look_a(3'd3, 3'd2, 1'b0, 16'h0);
    tick();
    set_fu(1, 1'b0, 3'd0, 16'h0);
    chk("wb_cdb_valid", 32'(cdb_valid), 1);
    chk("wb_cdb_tag", 32'(cdb_tag), 2);
    chk("wb_cdb_data", 32'(cdb_data), 32'h42);
    chk("wb_write", 32'(write), 1);
    chk("wb_address", 32'(address), 3);
    chk("wb_data", 32'(data), 32'h42);
    look_a(3'd3, 3'd0, 1'b1, 16'h0042);
    tick();
    chk("wb_after_write", 32'(write), 0);
    look_a(3'd3, 3'd0, 1'b0, 16'h0);

    // Superseded result: rd 5 renamed tag 1 then tag 4
    do_issue(3'd5, 3'd1);
    tick();
    do_issue(3'd5, 3'd4);
    tick();
    issue_valid = 1'b0;
    look_a(3'd5, 3'd4, 1'b0, 16'h0);
    set_fu(0, 1'b1, 3'd1, 16'h1111);
    #1;
    chk("sup_grant0", 32'(fu_grant), 32'(3'b001));
    tick();
    set_fu(0, 1'b0, 3'd0, 16'h0);
    chk("sup_cdb_valid0", 32'(cdb_valid), 1);
    chk("sup_cdb_tag0", 32'(cdb_tag), 1);
    chk("sup_write0", 32'(write), 0);
    set_fu(2, 1'b1, 3'd4, 16'h4444);
    #1;
    chk("sup_grant2", 32'(fu_grant), 32'(3'b100));
    tick();
    set_fu(2, 1'b0, 3'd0, 16'h0);
    chk("sup_cdb_tag2", 32'(cdb_tag), 4);
    chk("sup_write2", 32'(write), 1);
    chk("sup_address2", 32'(address), 5);
    chk("sup_data2", 32'(data), 32'h4444);
    look_a(3'd5, 3'd0, 1'b1, 16'h4444);
    tick();
    look_a(3'd5, 3'd0, 1'b0, 16'h0);

    // Same-edge issue and clear of rd 2
    do_issue(3'd2, 3'd3);
    tick();
    issue_valid = 1'b0;
    look_a(3'd2, 3'd3, 1'b0, 16'h0);
    set_fu(1, 1'b1, 3'd3, 16'h3333);
    do_issue(3'd2, 3'd6);
    #1;
    chk("same_grant", 32'(fu_grant), 32'(3'b010));
    tick();
    set_fu(1, 1'b0, 3'd0, 16'h0);
    issue_valid = 1'b0;
    chk("same_write", 32'(write), 1);
    chk("same_address", 32'(address), 2);
    chk("same_data", 32'(data), 32'h3333);
    tick();
    chk("same_after_write", 32'(write), 0);
    look_a(3'd2, 3'd6, 1'b0, 16'h0);

    // Forwarding of a pending bank write on port a, independent port b
    do_issue(3'd4, 3'd7);
    tick();
    issue_valid = 1'b0;
    set_fu(0, 1'b1, 3'd7, 16'h1234);
    #1;
    chk("fwd_grant", 32'(fu_grant), 32'(3'b001));
    tick();
    set_fu(0, 1'b0, 3'd0, 16'h0);
    chk("fwd_write", 32'(write), 1);
    chk("fwd_address", 32'(address), 4);
    look_a(3'd4, 3'd0, 1'b1, 16'h1234);
    src_b_addr = 3'd0;
    #1;
    chk("fwd_b0_tag", 32'(src_b_tag), 0);
    chk("fwd_b0_fwd", 32'(src_b_fwd), 0);
    src_b_addr = 3'd2;
    #1;
    chk("fwd_b2_tag", 32'(src_b_tag), 6);
    chk("fwd_b2_fwd", 32'(src_b_fwd), 0);

    // Reset mid-operation overrides issue and grant
    reset_n = 1'b0;
    set_fu(1, 1'b1, 3'd6, 16'h6666);
    do_issue(3'd3, 3'd5);
    #1;
    chk("mid_rst_grant", 32'(fu_grant), 0);
    tick();
    reset_n = 1'b1;
    issue_valid = 1'b0;
    src_b_addr = 3'd0;
    chk("mid_rst_write", 32'(write), 0);
    chk("mid_rst_cdb_valid", 32'(cdb_valid), 0);
    chk("mid_rst_address", 32'(address), 0);
    chk("mid_rst_data", 32'(data), 0);
    for (int r = 1; r < 8; r++) look_a(3'(r), 3'd0, 1'b0, 16'h0);
    #1;
    chk("post_rst_grant", 32'(fu_grant), 32'(3'b010));
    tick();
    set_fu(1, 1'b0, 3'd0, 16'h0);
    chk("post_rst_cdb_valid", 32'(cdb_valid), 1);
    chk("post_rst_cdb_tag", 32'(cdb_tag), 6);
    chk("post_rst_cdb_data", 32'(cdb_data), 32'h6666);
    chk("post_rst_write", 32'(write), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cdb_writeback_scheduler.md
Name: cdb_writeback_scheduler

Overview:
- Arbitrates the Common Data Bus between functional units (adder, multiplier, load unit) that hold finished results.
- Broadcasts one result per cycle and maintains the register status table (Qi tag per architectural register R1..R7).
- Drives the register bank's single write port (data, address, write), so a register is written only by its latest renaming producer.
- Sits between the reservation stations / functional units and the 7x16-bit register bank.

Parameters:
NUM_FU, 3, number of requesting functional units
TAGW, 3, reservation-station tag width; tag 0 means "no producer / value ready"
DW, 16, data width, matches register bank

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  synchronous, active-low reset
issue_valid  in  1  instruction issued this cycle
issue_rd  in  3  destination register of issued instruction (0 = none)
issue_tag  in  TAGW  reservation-station tag assigned to the issued instruction
src_a_addr, src_b_addr  in  3 each  source register lookup for the issuing instruction
src_a_tag, src_b_tag  out  TAGW each  pending producer tag (0 = value available)
src_a_fwd, src_b_fwd  out  1 each  value must be taken from src_*_data, not the register bank
src_a_data, src_b_data  out  DW each  forwarded value
fu_req  in  NUM_FU  result ready, per FU
fu_tag  in  NUM_FU*TAGW  result tag per FU, FU i at bits [i*TAGW +: TAGW]
fu_data  in  NUM_FU*DW  result data per FU
fu_grant  out  NUM_FU  one-hot grant, combinational
cdb_valid  out  1  CDB broadcast valid (registered)
cdb_tag  out  TAGW  broadcast tag
cdb_data  out  DW  broadcast data
write  out  1  register bank write enable (registered)
address  out  3  register bank write address
data  out  DW  register bank write data

Behaviour:
- Reset (reset_n low at a rising edge):
  - qi[1..7] = 0.
  - cdb_valid = 0, cdb_tag = 0, cdb_data = 0.
  - write = 0, address = 0, data = 0.
  - Round-robin pointer = NUM_FU-1, so FU0 has highest priority first.
  - Reset overrides issue and grant in the same cycle. Results in flight are dropped and the FUs keep requesting.
- Arbitration, cycle N:
  - Eligible requesters are those with fu_req[i] = 1 and fu_tag[i] != 0. Requests with tag 0 are never granted.
  - Search starts at pointer+1 and wraps modulo NUM_FU. The first eligible requester gets fu_grant = 1; all other grants are 0.
  - At most one grant per cycle. No eligible requester means no grant.
- FU handshake:
  - An FU holds req, tag and data stable until it sees its grant.
  - The granted FU treats the rising edge ending cycle N as consumed. It may present a new result in N+1.
- On the edge ending cycle N with grant to FU w (tag T):
  - pointer <= w.
  - cdb_valid <= 1, cdb_tag <= T, cdb_data <= data of w.
  - If some r in 1..7 has qi[r] == T (at most one): write <= 1, address <= r, data <= result, qi[r] <= 0.
  - Otherwise write <= 0; the result was superseded by a later rename.
  - With no grant: cdb_valid <= 0, write <= 0.
  - CDB and register-bank write therefore appear one cycle after the grant. The bank captures the value at the end of N+1.
- Issue, at the same edge: if issue_valid and issue_rd != 0, qi[issue_rd] <= issue_tag.
  - If issue_rd matches the register being cleared by the grant, issue wins: qi takes issue_tag.
  - The register bank write still occurs in that case.
  - issue_rd = 0 changes no state.
- Source lookup (combinational, evaluated independently for a and b):
  - Address 0: tag = 0, fwd = 0.
  - If write == 1 and address == src_addr: fwd = 1, src_data = data, tag = 0. This covers the value not yet in the bank.
  - Else if qi[src] != 0 and qi[src] equals the tag granted this cycle: tag stays qi[src]. The issuing RS must capture it from the CDB in the next cycle.
  - Otherwise: tag = qi[src], fwd = 0.
  - Lookup reflects qi before this cycle's issue, so an instruction reading its own rd sees the previous producer.

Test Plan:
- Reset, then idle: after reset_n = 0 for one edge, all outputs are 0. fu_req = 0 for 5 cycles gives cdb_valid = 0 and write = 0 throughout.
- Single writeback: issue rd = 3, tag = 2. FU1 requests tag 2, data 0x0042. Required: fu_grant = 010 that cycle; next cycle cdb_valid = 1, cdb_tag = 2, write = 1, address = 3, data = 0x0042; qi[3] = 0.
- Round-robin: all three FUs request continuously with distinct nonzero tags. Grants go 001, 010, 100, 001. A request with tag 0 is never granted.
- Superseded result: issue rd = 5 tag 1, then rd = 5 tag 4. FU0 broadcasts tag 1 and gets cdb_valid = 1 with write = 0. FU2 then broadcasts tag 4 and gets write = 1, address = 5.
- Same-cycle issue and clear: qi[2] = 3; grant tag 3 while issuing rd = 2 tag 6. Next cycle write = 1 to address 2 and qi[2] = 6.
- Forwarding: the cycle write = 1 to address 4 with data 0x1234, look up src_a_addr = 4. Required: src_a_fwd = 1, src_a_data = 0x1234, src_a_tag = 0.
- Reset mid-operation: assert reset_n = 0 while write = 1 and qi is nonzero. Next cycle write = 0 and all qi = 0.
